// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle execute-stage ALU.
package alu_pkg;

  // Operation encoding as presented on the op port.
  typedef enum logic [1:0] {
    OP_ZERO = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_MUL  = 2'd3
  } op_e;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DONE     = 2'd2
  } state_e;

  // Bit positions inside the packed status-flag vector.
  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_CARRY = 1;
  localparam int unsigned FLAG_OVF   = 2;
  localparam int unsigned FLAG_W     = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, LSB first.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH:0]     partial_c;

  // Load on start, otherwise add-and-shift the upper accumulator half each busy cycle.
  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    partial_c = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CNT_W'(WIDTH - 1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = {partial_c, acc_q[WIDTH-1:1]};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes and status flags.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf
);

  state_e              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [WIDTH-1:0]    result_hi_q, result_hi_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;

  logic                accept_c;
  logic                mul_start_c;
  logic                mul_busy;
  logic                mul_done;
  logic [2*WIDTH-1:0]  mul_product;

  logic [WIDTH:0]      sum_c;
  logic [WIDTH:0]      diff_c;
  logic [WIDTH-1:0]    alu_res_c;
  logic [FLAG_W-1:0]   alu_flags_c;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start_c),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Handshake: accept when idle, or when the held result is being consumed.
  assign in_ready = !rst && !mul_busy &&
                    ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept_c = in_valid && in_ready;

  // Single-cycle ops and their flags, evaluated on the live request operands.
  always_comb begin
    sum_c       = {1'b0, a} + {1'b0, b};
    diff_c      = {1'b0, a} - {1'b0, b};
    alu_res_c   = '0;
    alu_flags_c = '0;
    case (op_e'(op))
      OP_ADD: begin
        alu_res_c               = sum_c[WIDTH-1:0];
        alu_flags_c[FLAG_CARRY] = sum_c[WIDTH];
        alu_flags_c[FLAG_OVF]   = (a[WIDTH-1] == b[WIDTH-1]) &&
                                  (sum_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_c               = diff_c[WIDTH-1:0];
        alu_flags_c[FLAG_CARRY] = diff_c[WIDTH];
        alu_flags_c[FLAG_OVF]   = (a[WIDTH-1] != b[WIDTH-1]) &&
                                  (diff_c[WIDTH-1] != a[WIDTH-1]);
      end
      default: alu_res_c = '0;
    endcase
    alu_flags_c[FLAG_ZERO] = (alu_res_c == '0);
  end

  // Next-state and registered-output logic; a new accept overrides the drain path.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    mul_start_c = 1'b0;

    case (state_q)
      ST_IDLE: out_valid_d = 1'b0;
      ST_MUL_BUSY: begin
        if (mul_done) begin
          result_d           = mul_product[WIDTH-1:0];
          result_hi_d        = mul_product[2*WIDTH-1:WIDTH];
          flags_d            = '0;
          flags_d[FLAG_ZERO] = (mul_product[WIDTH-1:0] == '0);
          flags_d[FLAG_OVF]  = (mul_product[2*WIDTH-1:WIDTH] != '0);
          out_valid_d        = 1'b1;
          state_d            = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept_c) begin
      if (op_e'(op) == OP_MUL) begin
        mul_start_c = 1'b1;
        out_valid_d = 1'b0;
        state_d     = ST_MUL_BUSY;
      end else begin
        result_d    = alu_res_c;
        result_hi_d = '0;
        flags_d     = alu_flags_c;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign result_hi  = result_hi_q;
  assign flag_zero  = flags_q[FLAG_ZERO];
  assign flag_carry = flags_q[FLAG_CARRY];
  assign flag_ovf   = flags_q[FLAG_OVF];

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (WIDTH=32).
module tb_alu_mc;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] h;
    logic         z;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         flag_zero;
  logic         flag_carry;
  logic         flag_ovf;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .result_hi  (result_hi),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf)
  );

  // Reference model using wide integer arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    logic [63:0] u;
    longint      sx, sy, ss;
    e  = '0;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      2'd1: begin
        u   = {32'd0, x} + {32'd0, y};
        e.r = u[31:0];
        e.c = u[32];
        ss  = sx + sy;
        e.o = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      2'd2: begin
        e.r = x - y;
        e.c = (x < y);
        ss  = sx - sy;
        e.o = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      2'd3: begin
        u   = 64'(x) * 64'(y);
        e.r = u[31:0];
        e.h = u[63:32];
        e.o = (u[63:32] != 32'd0);
      end
      default: e.r = '0;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  // Scoreboard: pop and compare on every handshake seen at the falling edge.
  initial begin
    exp_t e, g;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        g = {result, result_hi, flag_zero, flag_carry, flag_ovf};
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected: got r=%h h=%h zco=%b%b%b, required no output",
                   result, result_hi, flag_zero, flag_carry, flag_ovf);
        end else begin
          e = sb.pop_front();
          if (g !== e)
            $display("FAIL sb_result: got r=%h h=%h zco=%b%b%b, required r=%h h=%h zco=%b%b%b",
                     g.r, g.h, g.z, g.c, g.o, e.r, e.h, e.z, e.c, e.o);
          else
            n_pass++;
        end
      end
    end
  end

  // Present a request, wait (bounded) for in_ready, push expectation, return #1 after the accept edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    n = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      $display("FAIL accept_timeout: in_ready=%b, required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(model(o, x, y));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 2'($urandom_range(0, 3));
  endtask

  task automatic drain(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 2'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b, required 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b, required 0", in_ready); else n_pass++;
    n_checks++; if ({result, result_hi} !== 64'd0) $display("FAIL rst_result: got %h_%h, required 0", result_hi, result); else n_pass++;
    n_checks++; if ({flag_zero, flag_carry, flag_ovf} !== 3'b000) $display("FAIL rst_flags: got %b%b%b, required 000", flag_zero, flag_carry, flag_ovf); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b, required 1", in_ready); else n_pass++;
  endtask

  task automatic test_add();
    issue(2'd1, 32'hFFFF_FFFF, 32'h1);
    idle_inputs();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL add_latency: out_valid=%b, required 1", out_valid); else n_pass++;
    drain(2);
  endtask

  task automatic test_sub();
    issue(2'd2, 32'h8000_0000, 32'h1);
    issue(2'd2, 32'd3, 32'd5);
    idle_inputs();
    drain(2);
  endtask

  task automatic test_mul();
    int cyc;
    bit ready_seen;
    issue(2'd3, 32'h0001_0000, 32'h0001_0000);
    idle_inputs();
    cyc = 0; ready_seen = 0;
    while (!out_valid && cyc < 100) begin
      if (in_ready) ready_seen = 1;
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++; if (cyc != 33) $display("FAIL mul_latency: got %0d cycles, required 33", cyc); else n_pass++;
    n_checks++; if (ready_seen) $display("FAIL mul_busy_ready: in_ready seen 1, required 0"); else n_pass++;
    drain(2);
    issue(2'd3, 32'd7, 32'd6);
    idle_inputs();
    drain(40);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    issue(2'd1, 32'd2, 32'd3);
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid: cycle %0d got %b, required 1", i, out_valid); else n_pass++;
      n_checks++; if (result !== 32'd5) $display("FAIL bp_result: cycle %0d got %h, required 5", i, result); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: cycle %0d got %b, required 0", i, in_ready); else n_pass++;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(2'd1, 32'd10, 32'd20);
    idle_inputs();
    n_checks++; if (out_valid !== 1'b1 || result !== 32'd30)
      $display("FAIL bp_handoff: valid=%b result=%h, required 1/0000001e", out_valid, result); else n_pass++;
    drain(2);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xs[4];
    logic [W-1:0] ys[4];
    exp_t e;
    xs = '{32'h7FFF_FFFF, 32'd100, 32'h8000_0000, 32'h1234_5678};
    ys = '{32'd1, 32'd200, 32'h8000_0000, 32'h1111_1111};
    for (int i = 0; i < 4; i++) begin
      issue(2'd1, xs[i], ys[i]);
      e = model(2'd1, xs[i], ys[i]);
      n_checks++; if (out_valid !== 1'b1 || result !== e.r)
        $display("FAIL b2b_result: op %0d valid=%b result=%h, required 1/%h", i, out_valid, result, e.r); else n_pass++;
    end
    issue(2'd0, 32'd5, 32'd9);
    idle_inputs();
    drain(2);
  endtask

  task automatic test_reset_mid_mul();
    bit stale;
    issue(2'd3, 32'h0000_FFFF, 32'h0000_FFFF);
    idle_inputs();
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    sb.delete();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmul_valid: got %b, required 0", out_valid); else n_pass++;
    n_checks++; if ({result, result_hi, flag_zero, flag_carry, flag_ovf} !== 67'd0)
      $display("FAIL rstmul_outputs: got r=%h h=%h zco=%b%b%b, required 0", result, result_hi, flag_zero, flag_carry, flag_ovf); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL rstmul_in_ready: got %b, required 0", in_ready); else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rstmul_release_ready: got %b, required 1", in_ready); else n_pass++;
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) stale = 1;
    end
    n_checks++; if (stale) $display("FAIL rstmul_stale: out_valid seen 1, required 0"); else n_pass++;
    @(posedge clk); #1;
    issue(2'd1, 32'd1, 32'd1);
    idle_inputs();
    drain(2);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    n_checks++; if (sb.size() != 0) $display("FAIL sb_drain: %0d results outstanding, required 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Multi-cycle, parametrised successor of the datapath ALU.
- Combinational ops (ZERO/ADD/SUB) complete with 1-cycle registered latency; MUL uses an iterative shift-add unit, one bit per cycle, and returns the full 2·WIDTH product.
- Valid/ready handshakes on both sides; status flags for the processor's branch/compare logic.
- Sits between decode/operand read and writeback in the execute stage; stalls the pipeline through backpressure.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- CNT_W, $clog2(WIDTH), multiply iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept a request this cycle.
- op  in  2  0=ZERO, 1=ADD, 2=SUB, 3=MUL.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  low WIDTH bits of the result.
- result_hi  out  WIDTH  high product half for MUL; 0 for other ops.
- flag_zero  out  1  result == 0.
- flag_carry  out  1  ADD: carry-out; SUB: borrow (a < b unsigned); others 0.
- flag_ovf  out  1  ADD/SUB: signed overflow; MUL: result_hi != 0; ZERO: 0.

Behaviour:
- Reset (async, active-high) forces: state=IDLE, in_ready=0 while rst is high, out_valid=0, result=0, result_hi=0, all flags=0, counter=0. Reset mid-MUL abandons the operation; no result is produced.
- FSM states: IDLE, MUL_BUSY, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Request accepted on a rising edge when in_valid && in_ready.
- op, a and b are sampled only at acceptance. Later changes to the inputs have no effect.
- ZERO/ADD/SUB accepted: compute combinationally, register all outputs, go to DONE. out_valid is high in the cycle after acceptance (latency 1).
- MUL accepted: latch a and b, clear the accumulator, counter=WIDTH-1, go to MUL_BUSY.
  - Each MUL_BUSY cycle processes one multiplier bit, LSB first.
  - At counter==0, register the product, flags and result_hi, then go to DONE.
  - out_valid rises exactly WIDTH+1 cycles after the acceptance edge (33 for WIDTH=32). MUL is unsigned.
- DONE: out_valid=1. result, result_hi and flags are held stable while out_ready=0.
  - On out_ready=1 with no new accept: go to IDLE; out_valid=0 next cycle.
  - On out_ready=1 with a simultaneous accept: handoff and acceptance happen in the same cycle.
    - ZERO/ADD/SUB: stay in DONE with the new result. Full throughput, one result per cycle.
    - MUL: go to MUL_BUSY.
- in_ready=0 throughout MUL_BUSY.
- Arithmetic is WIDTH-bit wrap-around. Carry uses a WIDTH+1 bit sum.
- Signed overflow:
  - ADD: sign(a)==sign(b) and sign(result) differs.
  - SUB: sign(a)!=sign(b) and sign(result)!=sign(a).
- flag_zero examines result only, not result_hi.
- Outputs while out_valid=0 are don't-care for the bench, but must be registered (no combinational path from a/b to outputs).

Decomposition:
- Package alu_pkg:
  - op enum (OP_ZERO, OP_ADD, OP_SUB, OP_MUL, 2 bits).
  - FSM state enum.
  - Flag bit-index constants, for the later packed-flag writeback.
- Sub-module alu_mul_seq: shift-add multiplier.
  - Interface: start, a, b, busy, done, product[2·WIDTH].
  - Owns the counter and accumulator. alu_mc owns the FSM, handshake and flag logic.

Test Plan:
- ADD a=0xFFFFFFFF, b=0x1, out_ready=1 -> next cycle out_valid=1, result=0, flag_zero=1, flag_carry=1, flag_ovf=0, result_hi=0.
- SUB a=0x80000000, b=0x1 -> result=0x7FFFFFFF, flag_ovf=1, flag_carry=0. Then SUB a=3, b=5 -> result=0xFFFFFFFE, flag_carry=1.
- MUL a=0x00010000, b=0x00010000 -> out_valid exactly 33 cycles after accept, result=0, result_hi=1, flag_zero=1, flag_ovf=1, in_ready=0 throughout. Then MUL 7×6 -> result=42, flag_ovf=0.
- Backpressure: ADD 2+3 with out_ready=0 for 5 cycles -> out_valid stays 1, result=5 stable, in_ready=0. Raise out_ready with ADD 10+20 pending -> handoff of 5 and accept of 10+20 in the same cycle, next cycle result=30.
- Back-to-back: four ADDs in consecutive cycles with out_ready=1 -> four results on four consecutive cycles, in order. Then ZERO a=5, b=9 -> result=0, flag_zero=1, carry and ovf 0.
- Reset: assert rst asynchronously 10 cycles into a MUL -> out_valid=0 and all outputs 0 immediately. After release, in_ready=1 and no stale result appears; a following ADD 1+1 returns 2.
